// File: rtl/uart_rx_oversampled.sv
// Oversampled (16x) UART receiver: 2-flop synchroniser, start validation, mid-bit sampling.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  // Tick counter must also reach SB_TICK-1 in STOP, so it grows beyond 4 bits for 1.5/2 stop bits
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] TICK_MID  = SW'(7);
  localparam logic [SW-1:0] TICK_LAST = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_s_q;
  logic [SW-1:0]     s_cnt_q, s_cnt_d;
  logic [NW-1:0]     n_cnt_q, n_cnt_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic              pbit_q, pbit_d;
  logic              perr_q, perr_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      n_cnt_q   <= '0;
      b_q       <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q    <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_cnt_q   <= n_cnt_d;
      b_q       <= b_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbit_q    <= pbit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    pbit_d  = pbit_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == TICK_MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == TICK_LAST) begin
            b_d     = {rx_s_q, b_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == TICK_LAST) begin
            pbit_d  = rx_s_q;
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            dout_d  = b_q;
            ferr_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^b_q) ^ pbit_q;
`endif
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

UART receive datapath clocked by the system clock and paced by the single-cycle oversampling tick from the team's parametrized modulus counter configured as a baud generator, at 16 ticks per bit. It synchronises the asynchronous serial line, detects and validates the start bit, and samples each data bit at mid-bit. It presents the assembled byte with a one-cycle done strobe and error flags to the downstream receive FIFO/consumer.

## Interface
- DBIT, 8, number of data bits per frame (5..9), sent LSB first
- SB_TICK, 16, ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- s_tick  input  1  oversampling strobe, one clk wide, 16 per bit period
- rx  input  1  asynchronous serial line, idle high
- dout  output  DBIT  last received data word
- rx_done_tick  output  1  one-clk pulse, dout/flags valid from this cycle
- frame_err  output  1  stop bit sampled low on last frame
- parity_err  output  1  parity mismatch on last frame (see Configuration)

## Operation
- rx passes through a 2-flop synchroniser (both flops reset to 1); all FSM decisions use the synchronised value rx_s.
- Registers: state, s_cnt (4 bits, counts ticks), n_cnt (ceil(log2 DBIT) bits), b_reg (DBIT-bit shift register).
- IDLE: on rx_s==0 (tick not required) -> START, s_cnt=0.
- START: on s_tick, if s_cnt==7: rx_s==0 -> DATA with s_cnt=0, n_cnt=0; rx_s==1 -> IDLE (glitch rejected, no strobe, flags unchanged). Otherwise s_cnt+1.
- DATA: on s_tick, if s_cnt==15: b_reg = {rx_s, b_reg[DBIT-1:1]}, s_cnt=0; if n_cnt==DBIT-1 -> PARITY (macro defined) or STOP, else n_cnt+1. Otherwise s_cnt+1.
- PARITY (macro only): on s_tick with s_cnt==15: latch the sampled bit, s_cnt=0 -> STOP.
- STOP: counter compares against SB_TICK-1, so s_cnt widens to 5 bits when SB_TICK>16; implementer sizes it as clog2(SB_TICK). On s_tick with s_cnt==SB_TICK-1: dout=b_reg, frame_err=~rx_s, parity_err updated, rx_done_tick=1 for that clk -> IDLE.
- dout and the flags hold until the next completed frame; a rejected start or reset clears nothing except on reset.
- s_tick ignored in IDLE. rx activity in any non-IDLE state only affects sampled values.
- Frame errors do not suppress rx_done_tick; the consumer decides.

## Timing
- Reset values: dout=0, rx_done_tick=0, frame_err=0, parity_err=0, state=IDLE, counters=0, synchroniser=1.
- rx fall to IDLE->START transition: 2 clk (synchroniser) + 1 clk.
- Data bit k sampled at tick 8+16k+16 after start detection (mid-bit); stop sample at 8+16·DBIT+SB_TICK ticks (+16 with parity).
- rx_done_tick asserted the clk after the final-tick edge is registered; exactly one clk wide.
- Back-to-back frames: IDLE re-entered same edge as strobe; a start edge present in the next cycle is accepted.
- reset mid-frame: next clk returns to IDLE with all reset values; partial frame discarded, no strobe.
- s_tick held high continuously is legal (each clk counts as one tick).

## Configuration
- UART_RX_PARITY_EN defined: PARITY state present; one even-parity bit follows the data bits; parity_err = (^b_reg) ^ parity_bit at strobe.
- Undefined: no PARITY state, DATA goes directly to STOP, parity_err is a constant 0; port list unchanged.

## Test plan
- Reset held 3 clks mid-frame, then released -> all outputs 0, state IDLE, no rx_done_tick for that frame.
- s_tick every 4 clk, DBIT=8, send 0xA5 (LSB first), stop=1 -> one rx_done_tick, dout=0xA5, frame_err=0.
- rx low pulse of 5 ticks then high -> returns to IDLE, no strobe, dout keeps previous 0xA5.
- Send 0x3C with stop bit driven 0 -> dout=0x3C, frame_err=1, strobe still issued; next good frame 0x01 clears frame_err.
- Two frames 0x55 then 0xFF with zero idle gap -> two strobes, dout=0x55 then 0xFF.
- UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> parity_err=0; same data with parity bit 0 -> parity_err=1.
